// File: rtl/cordic_host_pkg.sv
// Shared types and width defaults for the CORDIC host bridge.
package cordic_host_pkg;

  localparam int ANGLE_W_DEF = 24;
  localparam int DATA_W_DEF  = 32;

  // One CORDIC result as buffered: cos in the upper half, sin in the lower.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] cos;
    logic [DATA_W_DEF-1:0] sin;
  } pair_t;

  // Which half of the head pair is currently presented downstream.
  typedef enum logic {
    PH_COS = 1'b0,
    PH_SIN = 1'b1
  } phase_t;

endpackage

// File: rtl/cordic_host_fifo.sv
// Show-ahead result-pair FIFO: head is valid the cycle after it is written.
// A push while full is accepted when a pop happens in the same cycle.
module cordic_host_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cordic_host_bridge.sv
// Host bridge: issues angles to the CORDIC under credit control, buffers
// the unthrottled cos/sin results and serializes them as cos,sin words.
// Optional popped-pair counter: define CORDIC_HOST_COUNT_EN.
module cordic_host_bridge
  import cordic_host_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iAngle_valid,
  input  logic [ANGLE_W-1:0] iAngle,
  output logic               oAngle_ready,
  output logic               oCordic_valid,
  output logic [ANGLE_W-1:0] oCordic_data,
  input  logic               iCordic_ready,
  input  logic               iResult_valid,
  input  logic [DATA_W-1:0]  iResult_cos,
  input  logic [DATA_W-1:0]  iResult_sin,
  output logic               oWord_valid,
  output logic [DATA_W-1:0]  oWord,
  output logic               oWord_last,
  input  logic               iWord_ready,
  output logic               oError,
  output logic [31:0]        oResult_count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]       count;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       credit;
  logic                credit_ok;
  logic                issue;
  logic                result_dec;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic [2*DATA_W-1:0] head;
  phase_t              phase;
  phase_t              phase_next;

  // Every slot is either buffered, reserved for an in-flight angle, or free.
  assign credit        = CW'(DEPTH) - count - inflight;
  assign credit_ok     = (credit != '0);
  assign oCordic_valid = iAngle_valid & credit_ok;
  assign oCordic_data  = iAngle;
  assign oAngle_ready  = iCordic_ready & credit_ok;
  assign issue         = oCordic_valid & iCordic_ready;
  assign result_dec    = iResult_valid & (inflight != '0);

  // In-flight angle count; an issue and a result in one cycle cancel.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      inflight <= '0;
    end else if (issue && !result_dec) begin
      inflight <= inflight + 1'b1;
    end else if (!issue && result_dec) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Sticky error: unsolicited result, or a result dropped for lack of space.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oError <= 1'b0;
    end else if (iResult_valid && ((inflight == '0) || (fifo_full && !pop))) begin
      oError <= 1'b1;
    end
  end

  cordic_host_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk       (iClk),
    .rst       (iReset),
    .push      (iResult_valid),
    .push_data ({iResult_cos, iResult_sin}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Serializer phase register.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      phase <= PH_COS;
    end else begin
      phase <= phase_next;
    end
  end

  // Serializer outputs and next phase; EMPTY is simply an empty FIFO.
  always_comb begin
    phase_next  = phase;
    oWord_valid = ~fifo_empty;
    oWord_last  = 1'b0;
    oWord       = '0;
    pop         = 1'b0;
    if (!fifo_empty) begin
      case (phase)
        PH_COS: begin
          oWord = head[2*DATA_W-1:DATA_W];
          if (iWord_ready) phase_next = PH_SIN;
        end
        PH_SIN: begin
          oWord      = head[DATA_W-1:0];
          oWord_last = 1'b1;
          if (iWord_ready) begin
            pop        = 1'b1;
            phase_next = PH_COS;
          end
        end
        default: phase_next = PH_COS;
      endcase
    end
  end

`ifdef CORDIC_HOST_COUNT_EN
  // Popped-pair counter, wraps naturally at 32 bits.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oResult_count <= '0;
    end else if (pop) begin
      oResult_count <= oResult_count + 32'd1;
    end
  end
`else
  assign oResult_count = '0;
`endif

endmodule

// File: tb/tb_cordic_host_bridge.sv
// Self-checking bench for cordic_host_bridge: queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_cordic_host_bridge;
  import cordic_host_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 24;
  localparam int DW    = 32;

  logic          iClk;
  logic          iReset;
  logic          iAngle_valid;
  logic [AW-1:0] iAngle;
  logic          oAngle_ready;
  logic          oCordic_valid;
  logic [AW-1:0] oCordic_data;
  logic          iCordic_ready;
  logic          iResult_valid;
  logic [DW-1:0] iResult_cos;
  logic [DW-1:0] iResult_sin;
  logic          oWord_valid;
  logic [DW-1:0] oWord;
  logic          oWord_last;
  logic          iWord_ready;
  logic          oError;
  logic [31:0]   oResult_count;

  cordic_host_bridge #(
    .DEPTH   (DEPTH),
    .ANGLE_W (AW),
    .DATA_W  (DW)
  ) dut (
    .iClk          (iClk),
    .iReset        (iReset),
    .iAngle_valid  (iAngle_valid),
    .iAngle        (iAngle),
    .oAngle_ready  (oAngle_ready),
    .oCordic_valid (oCordic_valid),
    .oCordic_data  (oCordic_data),
    .iCordic_ready (iCordic_ready),
    .iResult_valid (iResult_valid),
    .iResult_cos   (iResult_cos),
    .iResult_sin   (iResult_sin),
    .oWord_valid   (oWord_valid),
    .oWord         (oWord),
    .oWord_last    (oWord_last),
    .iWord_ready   (iWord_ready),
    .oError        (oError),
    .oResult_count (oResult_count)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_cos(input int j);
    return 32'hC0DE_0000 | 32'(j);
  endfunction

  function automatic logic [31:0] pat_sin(input int j);
    return 32'h5111_0000 | 32'(j);
  endfunction

  // ---------------- reference model ----------------
  pair_t       mq[$];
  int          m_infl;
  bit          m_err;
  bit          m_ph;
  int unsigned m_rc;
  bit          prev_stall;
  logic [31:0] prev_word;
  logic        prev_last;

  task automatic model_clear();
    mq.delete();
    m_infl     = 0;
    m_err      = 0;
    m_ph       = 0;
    m_rc       = 0;
    prev_stall = 0;
  endtask

  initial model_clear();

  always begin : compare
    int          credit;
    bit          e_valid;
    logic [31:0] e_word;
    bit          issue;
    bit          hs;
    bit          pop;
    pair_t       p;
    @(negedge iClk);
    if (iReset) model_clear();
    credit  = DEPTH - mq.size() - m_infl;
    e_valid = (mq.size() > 0);
    e_word  = e_valid ? (m_ph ? mq[0].sin : mq[0].cos) : 32'h0;
    chk("m_angle_ready",  oAngle_ready,  iCordic_ready && credit > 0);
    chk("m_cordic_valid", oCordic_valid, iAngle_valid && credit > 0);
    chk("m_cordic_data",  oCordic_data,  iAngle);
    chk("m_word_valid",   oWord_valid,   e_valid);
    chk("m_word",         oWord,         e_word);
    chk("m_word_last",    oWord_last,    e_valid && m_ph);
    chk("m_error",        oError,        m_err);
    chk("m_result_count", oResult_count, m_rc);
    if (prev_stall && !iReset) begin
      chk("stall_word", oWord, prev_word);
      chk("stall_last", oWord_last, prev_last);
    end
    prev_stall = oWord_valid && !iWord_ready && !iReset;
    prev_word  = oWord;
    prev_last  = oWord_last;
    @(posedge iClk);
    if (iReset) begin
      model_clear();
    end else begin
      credit = DEPTH - mq.size() - m_infl;
      issue  = iAngle_valid && iCordic_ready && credit > 0;
      hs     = (mq.size() > 0) && iWord_ready;
      pop    = hs && m_ph;
      if (pop) begin
        void'(mq.pop_front());
`ifdef CORDIC_HOST_COUNT_EN
        m_rc++;
`endif
      end
      if (hs) m_ph = !m_ph;
      if (iResult_valid) begin
        if (m_infl == 0) m_err = 1;
        else m_infl--;
        if (mq.size() < DEPTH) begin
          p.cos = iResult_cos;
          p.sin = iResult_sin;
          mq.push_back(p);
        end else begin
          m_err = 1;
        end
      end
      if (issue) m_infl++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic reset_pulse();
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    tick();
  endtask

  initial begin : stim
    int          npairs;
    logic [31:0] got[$];
    logic [31:0] exp_w;
    iReset = 1'b1; iAngle_valid = 0; iAngle = '0; iCordic_ready = 0;
    iResult_valid = 0; iResult_cos = '0; iResult_sin = '0; iWord_ready = 0;
    repeat (2) tick();
    #1;
    chk("rst_word_valid", oWord_valid, 1'b0);
    chk("rst_word", oWord, 32'h0);
    chk("rst_error", oError, 1'b0);
    tick();
    iReset = 1'b0;
    tick();

    // Single angle round trip.
    iAngle_valid = 1; iAngle = 24'h123456; iCordic_ready = 1; iWord_ready = 1;
    #1;
    chk("t1_cordic_valid", oCordic_valid, 1'b1);
    chk("t1_cordic_data", oCordic_data, 32'h123456);
    tick();
    iAngle_valid = 0;
    iResult_valid = 1; iResult_cos = 32'h3F80_0000; iResult_sin = 32'h0;
    tick();
    iResult_valid = 0;
    #1;
    chk("t1_cos_valid", oWord_valid, 1'b1);
    chk("t1_cos_word", oWord, 32'h3F80_0000);
    chk("t1_cos_last", oWord_last, 1'b0);
    tick();
    chk("t1_sin_word", oWord, 32'h0000_0000);
    chk("t1_sin_last", oWord_last, 1'b1);
    tick();
    chk("t1_empty", oWord_valid, 1'b0);

    // Credit exhaustion with output stalled.
    iWord_ready = 0; iAngle_valid = 1;
    for (int i = 0; i < 8; i++) begin
      iAngle = 24'(i);
      tick();
    end
    iAngle_valid = 0;
    #1;
    chk("t2_ready_low_inflight", oAngle_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      iResult_valid = 1; iResult_cos = pat_cos(i); iResult_sin = pat_sin(i);
      tick();
    end
    iResult_valid = 0;
    #1;
    chk("t2_ready_low_full", oAngle_ready, 1'b0);
    chk("t2_full_valid", oWord_valid, 1'b1);
    iWord_ready = 1;
    tick();
    chk("t2_ready_before_pop", oAngle_ready, 1'b0);
    tick();
    iWord_ready = 0;
    #1;
    chk("t2_ready_after_pop", oAngle_ready, 1'b1);

    // Refill to full, then pop and write in the same cycle.
    iAngle_valid = 1; iAngle = 24'hABCDEF;
    tick();
    iAngle_valid = 0;
    iResult_valid = 1; iResult_cos = pat_cos(8); iResult_sin = pat_sin(8);
    tick();
    iResult_valid = 0;
    #1;
    chk("t3_full_ready", oAngle_ready, 1'b0);
    iWord_ready = 1;
    tick();
    iResult_valid = 1; iResult_cos = pat_cos(9); iResult_sin = pat_sin(9);
    tick();
    iResult_valid = 0; iWord_ready = 0;
    #1;
    chk("t3_still_valid", oWord_valid, 1'b1);
`ifdef CORDIC_HOST_COUNT_EN
    chk("t3_result_count", oResult_count, 32'd3);
`else
    chk("t3_result_count", oResult_count, 32'd0);
`endif
    iWord_ready = 1;
    npairs = 0;
    for (int k = 0; k < 40 && npairs < 8; k++) begin
      if (oWord_valid && oWord_last) npairs++;
      tick();
    end
    chk("t3_drained_pairs", npairs, 32'd8);
    chk("t3_drained_empty", oWord_valid, 1'b0);

    // Issue and result in the same cycle leave inflight at one.
    reset_pulse();
    iWord_ready = 0; iAngle_valid = 1; iAngle = 24'h000111;
    tick();
    iResult_valid = 1; iResult_cos = pat_cos(20); iResult_sin = pat_sin(20);
    tick();
    iAngle_valid = 0;
    iResult_cos = pat_cos(21); iResult_sin = pat_sin(21);
    tick();
    iResult_valid = 0;
    #1;
    chk("t4_no_error", oError, 1'b0);
    iWord_ready = 1;
    repeat (5) tick();
    chk("t4_empty", oWord_valid, 1'b0);

    // Backpressure: toggle ready every cycle over four pairs.
    reset_pulse();
    iWord_ready = 0; iAngle_valid = 1;
    repeat (4) tick();
    iAngle_valid = 0;
    for (int i = 0; i < 4; i++) begin
      iResult_valid = 1; iResult_cos = pat_cos(30 + i); iResult_sin = pat_sin(30 + i);
      tick();
    end
    iResult_valid = 0;
    for (int k = 0; k < 40 && got.size() < 8; k++) begin
      iWord_ready = (k % 2 == 0);
      #1;
      if (oWord_valid && iWord_ready) got.push_back(oWord);
      tick();
    end
    iWord_ready = 0;
    chk("t5_word_total", got.size(), 32'd8);
    for (int j = 0; j < 8; j++) begin
      exp_w = (j % 2 == 0) ? pat_cos(30 + j / 2) : pat_sin(30 + j / 2);
      chk($sformatf("t5_word%0d", j), (j < got.size()) ? got[j] : 32'hDEAD_DEAD, exp_w);
    end

    // Unsolicited result, then reset.
    reset_pulse();
    iResult_valid = 1; iResult_cos = 32'hAAAA_5555; iResult_sin = 32'h1234_ABCD;
    tick();
    iResult_valid = 0;
    #1;
    chk("t6_error_set", oError, 1'b1);
    chk("t6_valid", oWord_valid, 1'b1);
    chk("t6_cos", oWord, 32'hAAAA_5555);
    iWord_ready = 1;
    tick();
    chk("t6_sin", oWord, 32'h1234_ABCD);
    chk("t6_sin_last", oWord_last, 1'b1);
    iWord_ready = 0;
    iReset = 1;
    #1;
    chk("t6_rst_error", oError, 1'b0);
    chk("t6_rst_valid", oWord_valid, 1'b0);
    chk("t6_rst_word", oWord, 32'h0);
    tick();
    iReset = 0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench time limit expired");
  end

endmodule
